// File: rtl/dot_pkg.sv
// Shared types and screen geometry for the dot update queue.
// Entries carry a clamped coordinate so the display side never sees an off-screen value.
package dot_pkg;

   localparam int NUM_DOTS = 20;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int X_W      = 10;
   localparam int Y_W      = 9;
   localparam int ID_W     = $clog2(NUM_DOTS);

   typedef struct packed {
      logic            is_y;
      logic [ID_W-1:0] id;
      logic [X_W-1:0]  loc;
   } dot_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } dotq_state_t;

   // Y values share the X-wide field; bit 9 is always zero for a Y entry.
   function automatic logic [X_W-1:0] clamp_loc(input logic is_y, input logic [31:0] loc);
      logic [X_W-1:0] res;
      if (is_y) begin
         res = (loc > 32'(SCREEN_H - 1)) ? X_W'(SCREEN_H - 1) : {1'b0, loc[Y_W-1:0]};
      end else begin
         res = (loc > 32'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : loc[X_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/dotq_fifo.sv
// Synchronous show-ahead FIFO of dot entries; push visible at the head one cycle later.
// Pushes while full and pops while empty are ignored; push and pop together leave level unchanged.
module dotq_fifo
   import dot_pkg::*;
#(
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  dot_entry_t push_dat,
   input  logic       pop,
   output dot_entry_t head_dat,
   output logic       full,
   output logic       empty,
   output logic [AW:0] level
);

   dot_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: the pointers define which words are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/dot_update_queue.sv
// Queues processor dot writes and replays them to the display controller only after a screenEnd rising edge.
// STROBE_CYC+2 cycles per entry, up to MAX_PER_FRAME per gap; wr_ready drops when full. DOTQ_STATS_EN adds drop/late counters.
module dot_update_queue
   import dot_pkg::*;
#(
   parameter  int NUM_DOTS      = dot_pkg::NUM_DOTS,
   parameter  int DEPTH         = 32,
   parameter  int MAX_PER_FRAME = 40,
   parameter  int STROBE_CYC    = 2,
   localparam int LVL_W         = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             wr_is_y,
   input  logic [31:0]      wr_id,
   input  logic [31:0]      wr_loc,
   input  logic             screenEnd,
   output logic             dotWren,
   output logic             is_Yloc,
   output logic [31:0]      dotID,
   output logic [31:0]      dotLoc,
   output logic             busy,
   output logic [LVL_W-1:0] fifo_level
`ifdef DOTQ_STATS_EN
   ,
   output logic [15:0]      drop_cnt,
   output logic [15:0]      late_cnt
`endif
);

   localparam int SENT_W = $clog2(MAX_PER_FRAME + 1);
   localparam int SCNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

   dotq_state_t       state;
   dotq_state_t       state_nxt;
   logic              se_prev;
   logic              start;
   logic              id_ok;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              more;
   logic [SENT_W-1:0] sent;
   logic [SCNT_W-1:0] scnt;
   dot_entry_t        push_dat;
   dot_entry_t        head_dat;
   dot_entry_t        bus;

   assign start    = screenEnd & ~se_prev;
   assign wr_ready = ~full;
   assign id_ok    = (wr_id < 32'(NUM_DOTS));
   assign push     = wr_valid & wr_ready & id_ok;
   assign more     = ~empty & (sent < SENT_W'(MAX_PER_FRAME));

   always_comb begin
      push_dat      = '0;
      push_dat.is_y = wr_is_y;
      push_dat.id   = wr_id[ID_W-1:0];
      push_dat.loc  = clamp_loc(wr_is_y, wr_loc);
   end

   dotq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (full),
      .empty    (empty),
      .level    (fifo_level)
   );

   // The pop happens on the edge entering SETUP so the bus is valid for the whole SETUP cycle.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (start && !empty) begin
               state_nxt = SETUP;
               pop       = 1'b1;
            end
         end
         SETUP:  state_nxt = STROBE;
         STROBE: begin
            if (scnt == SCNT_W'(STROBE_CYC - 1)) state_nxt = HOLD;
         end
         HOLD: begin
            if (more) begin
               state_nxt = SETUP;
               pop       = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         se_prev <= 1'b0;
         scnt    <= '0;
         sent    <= '0;
         bus     <= '0;
      end else begin
         state   <= state_nxt;
         se_prev <= screenEnd;
         scnt    <= (state == STROBE) ? scnt + SCNT_W'(1) : '0;
         if (state == IDLE && start) begin
            sent <= pop ? SENT_W'(1) : '0;
         end else if (pop) begin
            sent <= sent + SENT_W'(1);
         end
         if (pop) bus <= head_dat;
      end
   end

   // Decoded straight from the state register so an async reset kills the strobe at once.
   assign dotWren = (state == STROBE);
   assign busy    = (state != IDLE);
   assign is_Yloc = bus.is_y;
   assign dotID   = 32'(bus.id);
   assign dotLoc  = 32'(bus.loc);

`ifdef DOTQ_STATS_EN
   logic drop_ev;
   logic late_ev;

   assign drop_ev = wr_valid & wr_ready & ~id_ok;
   assign late_ev = (start & busy) | ((state == HOLD) & ~empty & ~more);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt <= '0;
         late_cnt <= '0;
      end else begin
         if (drop_ev && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (late_ev && late_cnt != 16'hFFFF) late_cnt <= late_cnt + 16'd1;
      end
   end
`endif

endmodule
